// File: rtl/game_pkg.sv
// Shared types and helpers for the game controller: state encoding and
// the mapping from menu mode to the winning score.
package game_pkg;

  typedef enum logic [1:0] {
    ST_MENU     = 2'd0,
    ST_PLAY     = 2'd1,
    ST_CONTINUE = 2'd2,
    ST_FINAL    = 2'd3
  } game_state_e;

  // Points needed to win in a given mode.
  function automatic int unsigned mode_target(input int unsigned mode,
                                              input int unsigned win_step);
    return (mode + 1) * win_step;
  endfunction

  // Index width that stays at least one bit for degenerate counts.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/game_ctrl_fsm_if.sv
// Bundle of key inputs, score events and status outputs of the game controller.
// Inputs are plain levels; only their 0->1 transitions act as events. Outputs are
// registered and valid every cycle, so there is no valid/ready handshake.
interface game_ctrl_fsm_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int SCORE_W     = 6,
  parameter int NUM_MODES   = 4
);

  localparam int MODE_W = game_pkg::idx_w(NUM_MODES);
  localparam int WIN_W  = game_pkg::idx_w(NUM_PLAYERS);

  logic                           space_i;
  logic                           sellect_up_i;
  logic                           sellect_down_i;
  logic [NUM_PLAYERS-1:0]         score_event_i;
  logic [NUM_PLAYERS*SCORE_W-1:0] score_o;
  logic [MODE_W-1:0]              mode_o;
  logic                           is_menu_o;
  logic                           is_playing_o;
  logic                           is_continue_o;
  logic                           is_final_o;
  logic                           reset_o;
  logic [WIN_W-1:0]               winner_o;
  logic                           draw_o;
  game_pkg::game_state_e          state_dbg_o;

  modport master (
    output space_i, sellect_up_i, sellect_down_i, score_event_i,
    input  score_o, mode_o, is_menu_o, is_playing_o, is_continue_o, is_final_o,
    input  reset_o, winner_o, draw_o, state_dbg_o
  );

  modport slave (
    input  space_i, sellect_up_i, sellect_down_i, score_event_i,
    output score_o, mode_o, is_menu_o, is_playing_o, is_continue_o, is_final_o,
    output reset_o, winner_o, draw_o, state_dbg_o
  );

endinterface

// File: rtl/pos_edge_detect.sv
// Rising-edge detector: one-cycle pulse when the input goes from 0 to 1.
module pos_edge_detect (
  input  logic clk_i,
  input  logic reset_i,
  input  logic sig_i,
  output logic edge_o
);

  logic prev_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= sig_i;
    end
  end

  assign edge_o = sig_i & ~prev_q;

endmodule

// File: rtl/game_ctrl_fsm.sv
// Match controller: menu mode selection, scoring, pause between rounds and
// final result, driven by edge-detected keys and per-player hit events.
module game_ctrl_fsm
  import game_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int SCORE_W     = 6,
  parameter int NUM_MODES   = 4,
  parameter int WIN_STEP    = 3,
  parameter int ROUND_DELAY = 120
) (
  input logic             clk_i,
  input logic             reset_i,
  game_ctrl_fsm_if.slave  bus
);

  localparam int MODE_W = idx_w(NUM_MODES);
  localparam int WIN_W  = idx_w(NUM_PLAYERS);
  localparam int CNT_W  = idx_w(ROUND_DELAY);

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [MODE_W-1:0]  MODE_MAX  = MODE_W'(NUM_MODES - 1);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(ROUND_DELAY - 1);

  logic                   space_edge;
  logic                   up_edge;
  logic                   down_edge;
  logic [NUM_PLAYERS-1:0] score_edge;

  pos_edge_detect u_space_edge (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .sig_i   (bus.space_i),
    .edge_o  (space_edge)
  );

  pos_edge_detect u_up_edge (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .sig_i   (bus.sellect_up_i),
    .edge_o  (up_edge)
  );

  pos_edge_detect u_down_edge (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .sig_i   (bus.sellect_down_i),
    .edge_o  (down_edge)
  );

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_score_edge
    pos_edge_detect u_score_edge (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .sig_i   (bus.score_event_i[g]),
      .edge_o  (score_edge[g])
    );
  end

  game_state_e                        state_q;
  logic [MODE_W-1:0]                  mode_q;
  logic [NUM_PLAYERS-1:0][SCORE_W-1:0] score_q;
  logic [WIN_W-1:0]                   winner_q;
  logic                               draw_q;
  logic [CNT_W-1:0]                   cnt_q;
  logic                               is_menu_q;
  logic                               is_play_q;
  logic                               is_cont_q;
  logic                               is_final_q;
  logic                               round_rst_q;

  logic [MODE_W-1:0]                   mode_d;
  logic [NUM_PLAYERS-1:0][SCORE_W-1:0] score_d;
  logic [NUM_PLAYERS-1:0]              reached;
  logic [WIN_W-1:0]                    lead_idx;
  logic                                lead_found;
  logic                                tie;
  logic                                timeout;
  int unsigned                         target;

  // Menu selection: opposing edges in the same cycle cancel out.
  always_comb begin
    mode_d = mode_q;
    if (up_edge && !down_edge && (mode_q != MODE_MAX)) begin
      mode_d = mode_q + 1'b1;
    end else if (down_edge && !up_edge && (mode_q != '0)) begin
      mode_d = mode_q - 1'b1;
    end
  end

  // Scores as they would be after this cycle's hits, plus who reached the target.
  always_comb begin
    target     = mode_target(32'(mode_q), WIN_STEP);
    score_d    = score_q;
    reached    = '0;
    lead_idx   = '0;
    lead_found = 1'b0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (score_edge[p] && (score_q[p] != SCORE_MAX)) begin
        score_d[p] = score_q[p] + 1'b1;
      end
      reached[p] = (32'(score_d[p]) >= target);
      if (reached[p] && !lead_found) begin
        lead_idx   = WIN_W'(p);
        lead_found = 1'b1;
      end
    end
    tie = ($countones(reached) > 1);
  end

  assign timeout = (ROUND_DELAY != 0) && (cnt_q == CNT_LAST);

  // Status flags follow the state register one cycle behind it.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_MENU;
      mode_q      <= '0;
      score_q     <= '0;
      winner_q    <= '0;
      draw_q      <= 1'b0;
      cnt_q       <= '0;
      is_menu_q   <= 1'b0;
      is_play_q   <= 1'b0;
      is_cont_q   <= 1'b0;
      is_final_q  <= 1'b0;
      round_rst_q <= 1'b1;
    end else begin
      is_menu_q   <= (state_q == ST_MENU);
      is_play_q   <= (state_q == ST_PLAY);
      is_cont_q   <= (state_q == ST_CONTINUE);
      is_final_q  <= (state_q == ST_FINAL);
      round_rst_q <= (state_q != ST_PLAY);

      case (state_q)
        ST_MENU: begin
          mode_q <= mode_d;
          if (space_edge) begin
            score_q <= '0;
            state_q <= ST_PLAY;
          end
        end

        ST_PLAY: begin
          score_q <= score_d;
          if (|reached) begin
            winner_q <= lead_idx;
            draw_q   <= tie;
            state_q  <= ST_FINAL;
          end else if (|score_edge) begin
            cnt_q   <= '0;
            state_q <= ST_CONTINUE;
          end
        end

        ST_CONTINUE: begin
          if (space_edge || timeout) begin
            state_q <= ST_PLAY;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_FINAL: begin
          if (space_edge) begin
            score_q <= '0;
            state_q <= ST_MENU;
          end
        end

        default: begin
          state_q <= ST_MENU;
        end
      endcase
    end
  end

  assign bus.score_o       = score_q;
  assign bus.mode_o        = mode_q;
  assign bus.is_menu_o     = is_menu_q;
  assign bus.is_playing_o  = is_play_q;
  assign bus.is_continue_o = is_cont_q;
  assign bus.is_final_o    = is_final_q;
  assign bus.reset_o       = round_rst_q;
  assign bus.winner_o      = winner_q;
  assign bus.draw_o        = draw_q;
  assign bus.state_dbg_o   = state_q;

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Bench for game_ctrl_fsm: directed scenarios and random key/score traffic,
// checked cycle by cycle against a rule-level model through an expected queue.
module tb_game_ctrl_fsm;

  localparam int NP = 2;
  localparam int SW = 6;
  localparam int NM = 4;
  localparam int WS = 3;
  localparam int RD = 10;
  localparam int MW = 2;
  localparam int SNAP_W = NP*SW + MW + 5 + 1 + 1;
  // Snapshot layout: {scores, mode, flags{menu,play,cont,final,reset_o}, winner, draw}
  localparam int D_B   = 0;
  localparam int W_B   = 1;
  localparam int FL_LO = 2;
  localparam int MD_LO = 7;
  localparam int SC_LO = 9;

  localparam int M_MENU  = 0;
  localparam int M_PLAY  = 1;
  localparam int M_CONT  = 2;
  localparam int M_FINAL = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  game_ctrl_fsm_if #(.NUM_PLAYERS(NP), .SCORE_W(SW), .NUM_MODES(NM)) bus ();

  game_ctrl_fsm #(
    .NUM_PLAYERS (NP),
    .SCORE_W     (SW),
    .NUM_MODES   (NM),
    .WIN_STEP    (WS),
    .ROUND_DELAY (RD)
  ) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [SNAP_W-1:0] exp_q[$];
  int                tag_q[$];
  int                total = 0;
  int                bad   = 0;

  // ---------------- reference model ----------------
  int m_st      = M_MENU;
  int m_mode    = 0;
  int m_score[NP];
  int m_win     = 0;
  bit m_draw    = 1'b0;
  int m_elapsed = 0;
  bit m_prev_sp = 1'b0;
  bit m_prev_up = 1'b0;
  bit m_prev_dn = 1'b0;
  bit m_prev_se[NP];

  function automatic logic [SNAP_W-1:0] pack_snap(input logic [NP*SW-1:0] sc,
                                                  input logic [MW-1:0] md,
                                                  input logic [4:0] fl,
                                                  input logic w,
                                                  input logic d);
    return {sc, md, fl, w, d};
  endfunction

  task automatic model_step(input bit sp, input bit up, input bit dn,
                            input bit [NP-1:0] se, input bit r,
                            output logic [4:0] fl);
    bit e_sp, e_up, e_dn;
    bit e_se[NP];
    int tgt;
    int hits;
    int lead;
    bit any_hit;
    if (r) begin
      fl = 5'b00001;
      m_st = M_MENU; m_mode = 0; m_win = 0; m_draw = 1'b0; m_elapsed = 0;
      m_prev_sp = 1'b0; m_prev_up = 1'b0; m_prev_dn = 1'b0;
      for (int p = 0; p < NP; p++) begin
        m_score[p] = 0;
        m_prev_se[p] = 1'b0;
      end
      return;
    end
    fl = {m_st == M_MENU, m_st == M_PLAY, m_st == M_CONT, m_st == M_FINAL, m_st != M_PLAY};
    e_sp = sp && !m_prev_sp; m_prev_sp = sp;
    e_up = up && !m_prev_up; m_prev_up = up;
    e_dn = dn && !m_prev_dn; m_prev_dn = dn;
    any_hit = 1'b0;
    for (int p = 0; p < NP; p++) begin
      e_se[p] = se[p] && !m_prev_se[p];
      m_prev_se[p] = se[p];
      if (e_se[p]) any_hit = 1'b1;
    end
    case (m_st)
      M_MENU: begin
        if (e_up && !e_dn) m_mode = (m_mode < NM-1) ? m_mode + 1 : m_mode;
        else if (e_dn && !e_up) m_mode = (m_mode > 0) ? m_mode - 1 : 0;
        if (e_sp) begin
          for (int p = 0; p < NP; p++) m_score[p] = 0;
          m_st = M_PLAY;
        end
      end
      M_PLAY: begin
        tgt = (m_mode + 1) * WS;
        hits = 0;
        lead = -1;
        for (int p = 0; p < NP; p++) begin
          if (e_se[p] && m_score[p] < (1 << SW) - 1) m_score[p] = m_score[p] + 1;
          if (m_score[p] >= tgt) begin
            hits++;
            if (lead < 0) lead = p;
          end
        end
        if (hits > 0) begin
          m_win = lead;
          m_draw = (hits > 1);
          m_st = M_FINAL;
        end else if (any_hit) begin
          m_elapsed = 0;
          m_st = M_CONT;
        end
      end
      M_CONT: begin
        m_elapsed++;
        if (e_sp || (RD != 0 && m_elapsed == RD)) m_st = M_PLAY;
      end
      default: begin
        if (e_sp) begin
          for (int p = 0; p < NP; p++) m_score[p] = 0;
          m_st = M_MENU;
        end
      end
    endcase
  endtask

  // ---------------- driver ----------------
  task automatic tick(input bit sp, input bit up, input bit dn,
                      input bit [NP-1:0] se, input bit r);
    logic [4:0]       fl;
    logic [NP*SW-1:0] sc;
    @(posedge clk);
    #1;
    rst = r;
    bus.space_i = sp;
    bus.sellect_up_i = up;
    bus.sellect_down_i = dn;
    bus.score_event_i = se;
    model_step(sp, up, dn, se, r, fl);
    for (int p = 0; p < NP; p++) sc[p*SW +: SW] = SW'(m_score[p]);
    exp_q.push_back(pack_snap(sc, MW'(m_mode), fl, 1'(m_win), m_draw));
    tag_q.push_back(cyc + 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, '0, 0);
  endtask

  task automatic press_space();
    tick(1, 0, 0, '0, 0);
    tick(0, 0, 0, '0, 0);
  endtask

  task automatic hit(input bit [NP-1:0] se);
    tick(0, 0, 0, se, 0);
    tick(0, 0, 0, '0, 0);
  endtask

  // ---------------- monitor ----------------
  task automatic chk(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp_v);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [SNAP_W-1:0] e;
    logic [4:0]        act_fl;
    while (tag_q.size() > 0 && tag_q[0] <= cyc) begin
      e = exp_q.pop_front();
      void'(tag_q.pop_front());
      act_fl = {bus.is_menu_o, bus.is_playing_o, bus.is_continue_o, bus.is_final_o, bus.reset_o};
      chk("score", int'(bus.score_o), int'(e[SC_LO +: NP*SW]));
      chk("mode", int'(bus.mode_o), int'(e[MD_LO +: MW]));
      chk("flags", int'(act_fl), int'(e[FL_LO +: 5]));
      if (e[FL_LO + 1]) begin
        chk("winner", int'(bus.winner_o), int'(e[W_B]));
        chk("draw", int'(bus.draw_o), int'(e[D_B]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.space_i = 1'b0;
    bus.sellect_up_i = 1'b0;
    bus.sellect_down_i = 1'b0;
    bus.score_event_i = '0;
    for (int p = 0; p < NP; p++) begin
      m_score[p] = 0;
      m_prev_se[p] = 1'b0;
    end

    tick(0, 0, 0, '0, 1);
    tick(0, 0, 0, '0, 1);
    idle(2);

    // mode selection with saturation and cancelling edges
    for (int i = 0; i < 5; i++) begin
      tick(0, 1, 0, '0, 0);
      tick(0, 0, 0, '0, 0);
    end
    tick(0, 0, 1, '0, 0);
    tick(0, 0, 0, '0, 0);
    tick(0, 1, 1, '0, 0);
    idle(2);

    // hits in menu are ignored
    hit(2'b11);

    // single player wins in mode 0
    tick(0, 0, 0, '0, 1);
    idle(1);
    press_space();
    for (int i = 0; i < 3; i++) begin
      hit(2'b01);
      idle(1);
      if (i < 2) press_space();
    end
    idle(2);
    press_space();
    idle(2);

    // draw: both players at 2, then both hit together
    press_space();
    for (int i = 0; i < 2; i++) begin
      hit(2'b10);
      press_space();
      hit(2'b01);
      press_space();
    end
    hit(2'b11);
    idle(2);
    press_space();
    idle(1);

    // CONTINUE auto-resume
    press_space();
    hit(2'b10);
    idle(15);

    // held score input counts once
    for (int i = 0; i < 50; i++) tick(0, 0, 0, 2'b01, 0);
    idle(3);

    // reset during PLAY together with a score edge
    tick(0, 0, 0, 2'b10, 1);
    idle(3);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
           {$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0},
           $urandom_range(0, 499) == 0);
    end
    idle(2);

    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/game_ctrl_fsm.md
GAME_CTRL_FSM -- requirements
Module: game_ctrl_fsm

Interface
REQ-001 Parameter NUM_PLAYERS, default 2, number of players; legal range 2..4.
REQ-002 Parameter SCORE_W, default 6, per-player score width.
REQ-003 Parameter NUM_MODES, default 4, number of menu-selectable match lengths.
REQ-004 Parameter WIN_STEP, default 3, points per mode step; target score = (mode_o+1)*WIN_STEP.
REQ-005 Parameter ROUND_DELAY, default 120, CONTINUE auto-resume timeout in cycles; 0 disables timeout.
REQ-006 clk_i  in  1  single clock; all logic on rising edge.
REQ-007 reset_i  in  1  synchronous, active-high reset.
REQ-008 space_i  in  1  level input; start/continue/acknowledge key.
REQ-009 sellect_up_i, sellect_down_i  in  1 each  level inputs; menu mode selection.
REQ-010 score_event_i  in  NUM_PLAYERS  level; bit k high means player k scored (bullet hit an opponent).
REQ-011 score_o  out  NUM_PLAYERS*SCORE_W  packed scores, player 0 in LSBs.
REQ-012 mode_o  out  $clog2(NUM_MODES)  selected match mode.
REQ-013 is_menu_o, is_playing_o, is_continue_o, is_final_o  out  1 each  one-hot state flags.
REQ-014 reset_o  out  1  round reset to game objects; high in every state except PLAY.
REQ-015 winner_o  out  $clog2(NUM_PLAYERS)  winning player index, valid while is_final_o.
REQ-016 draw_o  out  1  several players reached target in the same cycle.

Function
REQ-017 space_i, sellect_up_i, sellect_down_i and each score_event_i bit SHALL be rising-edge detected; only a 0->1 transition counts as one event.
REQ-018 States SHALL be MENU, PLAY, CONTINUE, FINAL; state flags SHALL be registered and match the current state one cycle after each transition.
REQ-019 MENU: up edge increments mode_o, down edge decrements, both saturating at NUM_MODES-1 and 0; simultaneous up and down edges SHALL leave mode_o unchanged.
REQ-020 MENU: space edge clears all scores and moves to PLAY; mode_o SHALL then be frozen until the next MENU.
REQ-021 PLAY: every player with a score edge this cycle SHALL increment by 1, saturating at 2**SCORE_W-1; simultaneous edges all count.
REQ-022 PLAY: if any updated score >= target, go to FINAL; otherwise, if any score edge occurred, go to CONTINUE; otherwise stay.
REQ-023 FINAL entry: exactly one player at/above target sets winner_o to that index, draw_o=0; several set draw_o=1 and winner_o to lowest such index.
REQ-024 CONTINUE: space edge, or ROUND_DELAY cycles elapsed (when nonzero), returns to PLAY; the delay counter restarts on each CONTINUE entry.
REQ-025 FINAL: scores, winner_o and draw_o held; space edge returns to MENU, scores cleared, mode_o retained.
REQ-026 Score edges outside PLAY SHALL be ignored.
REQ-027 Unreachable state encodings SHALL recover to MENU next cycle.

Reset
REQ-028 On reset_i: state MENU, scores 0, mode_o 0, winner_o 0, draw_o 0, delay counter 0, edge-detector history 0, is_menu_o 0, other flags 0, reset_o 1; flags valid from the first post-reset cycle.
REQ-029 Reset mid-PLAY SHALL abort the match with no score update that cycle.

Structure
REQ-030 State enum and the mode-to-target function SHALL live in a shared package game_pkg.
REQ-031 Edge detection SHALL reuse the existing pos_edge_detect sub-module, one instance per detected input.

Verification
REQ-032 Reset, up edge x5, down edge x1 -> mode_o 3 then 2 (saturates at 3).
REQ-033 Mode 0, space, P0 scores 3 times with space between -> CONTINUE after first two, FINAL with winner_o=0, draw_o=0, score 3.
REQ-034 P1 at 2 and P0 at 2 (target 3), both score same cycle -> FINAL, draw_o=1, winner_o=0.
REQ-035 ROUND_DELAY=10, score in PLAY, no space -> is_playing_o reasserted 10 cycles after CONTINUE entry.
REQ-036 score_event_i[0] held high 50 cycles in PLAY -> score increments once only.
REQ-037 reset_i pulse during PLAY with simultaneous score edge -> MENU, all scores 0.
